entry_conditioner: RTL and testbench

Front-end stage for the combination lock. It turns the raw push button and raw slide switches into one clean, single-cycle-accepted entry event on the system clock. It synchronizes and debounces the active-low key and captures the switch value at the moment the press is confirmed. It then presents that value to the downstream lock state machine over a valid/ready handshake, so the lock FSM never clocks on a bouncing button.

---
 rtl/entry_conditioner.sv | 149 ++++++++++++++
 tb/tb_entry_conditioner.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/entry_conditioner.sv
// Push-button entry front end: synchronize, debounce, capture, handshake.
// Optional sticky overrun flag enabled by defining ENTRY_OVERRUN_EN.
module entry_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_WIDTH        = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_n,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                entry_ready,
  output logic                entry_valid,
  output logic [SW_WIDTH-1:0] entry_value,
  output logic                entry_is_digit,
  output logic                key_level,
  output logic                overrun
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic                key_m;
  logic                key_s;
  logic [SW_WIDTH-1:0] sw_m;
  logic [SW_WIDTH-1:0] sw_s;

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic                capture;
  logic                pressed;
  logic                take;

  // Two-flop synchronizers for the asynchronous key and switches
  always_ff @(posedge clk) begin
    if (rst) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      key_m <= key_n;
      key_s <= key_m;
      sw_m  <= sw;
      sw_s  <= sw_m;
    end
  end

  assign pressed = ~key_s;

  // Debounce state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Debounce next-state logic; capture fires once on press confirmation
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign key_level = (state == PRESSED) || (state == RELEASE_WAIT);

  // A capture only lands if the slot is empty or being drained this edge
  assign take = capture && (!entry_valid || entry_ready);

  // Entry holding register with valid/ready handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid    <= 1'b0;
      entry_value    <= '0;
      entry_is_digit <= 1'b0;
    end else if (take) begin
      entry_valid    <= 1'b1;
      entry_value    <= sw_s;
      entry_is_digit <= (32'(sw_s) <= 32'd9);
    end else if (entry_valid && entry_ready) begin
      entry_valid <= 1'b0;
    end
  end

`ifdef ENTRY_OVERRUN_EN
  // Sticky flag for a confirmed press lost to a pending entry
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (capture && entry_valid && !entry_ready) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_entry_conditioner.sv
// Self-checking bench for entry_conditioner with a run-length
// debounce reference model and randomized key/switch/ready stimulus.
module tb_entry_conditioner;

  localparam int D = 4;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_n;
  logic [W-1:0] sw;
  logic         entry_ready;
  logic         entry_valid;
  logic [W-1:0] entry_value;
  logic         entry_is_digit;
  logic         key_level;
  logic         overrun;

  int checks   = 0;
  int failures = 0;

  entry_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .SW_WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .sw(sw),
    .entry_ready(entry_ready),
    .entry_valid(entry_valid),
    .entry_value(entry_value),
    .entry_is_digit(entry_is_digit),
    .key_level(key_level),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

`ifdef ENTRY_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  // Reference model: key level flips after D+1 consecutive
  // synchronized samples disagreeing with it; a flip to pressed
  // captures the switches seen through the same 2-edge delay.
  bit           m_s1, m_s2;
  logic [W-1:0] m_w1, m_w2;
  int           m_run;
  bit           m_level, m_valid, m_digit, m_ovr;
  logic [W-1:0] m_value;

  always @(posedge clk) begin : model
    bit conf;
    conf = 1'b0;
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_w1 = '0;   m_w2 = '0;
      m_run = 0;   m_level = 1'b0;
      m_valid = 1'b0; m_value = '0;
      m_digit = 1'b0; m_ovr = 1'b0;
    end else begin
      if ((m_s2 == 1'b0) != m_level) begin
        m_run = m_run + 1;
        if (m_run == D + 1) begin
          m_level = !m_level;
          m_run = 0;
          conf = m_level;
        end
      end else begin
        m_run = 0;
      end
      if (conf) begin
        if (!m_valid || entry_ready) begin
          m_valid = 1'b1;
          m_value = m_w2;
          m_digit = (int'(m_w2) <= 9);
        end else if (OVR_EN) begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && entry_ready) begin
        m_valid = 1'b0;
      end
      m_s2 = m_s1; m_s1 = key_n;
      m_w2 = m_w1; m_w1 = sw;
    end
  end

  logic [W+3:0] obs, expv;
  assign obs  = {entry_valid, entry_value, entry_is_digit,
                 key_level, overrun};
  assign expv = {m_valid, m_value, m_digit, m_level, m_ovr};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; key_n = 1'b1; sw = '0; entry_ready = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", obs);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL reset_idle got=%h want=%h", obs, expv);
      end
    end
  endtask

  task automatic test_press();
    int first, highs;
    first = 0; highs = 0;
    sw = W'(6); entry_ready = 1'b1; key_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL press_model k=%0d got=%h want=%h", k, obs, expv);
      end
      if (entry_valid) begin
        highs++;
        if (first == 0) first = k;
      end
      if (k == 7) begin
        checks++;
        if ({entry_valid, entry_value, entry_is_digit, key_level}
            !== {1'b1, W'(6), 1'b1, 1'b1}) begin
          failures++;
          $display("FAIL press_edge7 v=%b val=%0d dig=%b lvl=%b want 1/6/1/1",
                   entry_valid, entry_value, entry_is_digit, key_level);
        end
      end
    end
    checks++;
    if (first != 7 || highs != 1) begin
      failures++;
      $display("FAIL press_latency first=%0d highs=%0d want 7/1",
               first, highs);
    end
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL press_release got=%h want=%h", obs, expv);
      end
    end
  endtask

  task automatic test_bounce();
    entry_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      key_n = (i >= 30) ? 1'b1 : ((i / 2) % 2 == 0 ? 1'b0 : 1'b1);
      tick();
      checks++;
      if (entry_valid !== 1'b0 || key_level !== 1'b0 ||
          obs !== expv) begin
        failures++;
        $display("FAIL bounce i=%0d v=%b lvl=%b want 0/0 (model %h got %h)",
                 i, entry_valid, key_level, expv, obs);
      end
    end
  endtask

  task automatic test_overrun();
    entry_ready = 1'b0;
    for (int ph = 0; ph < 4; ph++) begin
      key_n = ph[0];
      sw = (ph < 2) ? W'(3) : W'(9);
      for (int i = 0; i < 12; i++) begin
        tick();
        checks++;
        if (obs !== expv) begin
          failures++;
          $display("FAIL overrun_model ph=%0d got=%h want=%h",
                   ph, obs, expv);
        end
      end
    end
    checks++;
    if ({entry_valid, entry_value, overrun} !== {1'b1, W'(3), OVR_EN}) begin
      failures++;
      $display("FAIL overrun_hold v=%b val=%0d ovr=%b want 1/3/%b",
               entry_valid, entry_value, overrun, OVR_EN);
    end
    entry_ready = 1'b1;
    tick(); tick();
    checks++;
    if (entry_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_drain v=%b want 0", entry_valid);
    end
  endtask

  task automatic test_release_bounce();
    int n_entries;
    int pat [4] = '{10, 2, 1, 10};
    n_entries = 0;
    entry_ready = 1'b1; sw = W'(2);
    for (int ph = 0; ph < 4; ph++) begin
      key_n = ph[0];
      for (int i = 0; i < pat[ph]; i++) begin
        tick();
        checks++;
        if (obs !== expv) begin
          failures++;
          $display("FAIL relbounce_model ph=%0d got=%h want=%h",
                   ph, obs, expv);
        end
        if (entry_valid) begin
          n_entries++;
          checks++;
          if (entry_value !== W'(2)) begin
            failures++;
            $display("FAIL relbounce_value got=%0d want=2", entry_value);
          end
        end
      end
    end
    checks++;
    if (n_entries != 1 || key_level !== 1'b0) begin
      failures++;
      $display("FAIL relbounce_count entries=%0d lvl=%b want 1/0",
               n_entries, key_level);
    end
  endtask

  task automatic test_nondigit();
    entry_ready = 1'b0; sw = W'(12); key_n = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if ({entry_valid, entry_value, entry_is_digit}
        !== {1'b1, W'(12), 1'b0}) begin
      failures++;
      $display("FAIL nondigit v=%b val=%0d dig=%b want 1/12/0",
               entry_valid, entry_value, entry_is_digit);
    end
    key_n = 1'b1; entry_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL nondigit_model got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_reset_mid();
    int first;
    first = 0;
    entry_ready = 1'b1; sw = W'(5); key_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      rst = (k == 5);
      tick();
      if (k == 5) begin
        checks++;
        if (obs !== '0) begin
          failures++;
          $display("FAIL rstmid_zero got=%h want=0", obs);
        end
      end
      if (entry_valid && first == 0) first = k;
    end
    rst = 1'b0;
    checks++;
    if (first != 12) begin
      failures++;
      $display("FAIL rstmid_latency first=%0d want 12", first);
    end
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_random();
    int run;
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        key_n = ~key_n;
        run = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14)
                                          : $urandom_range(1, 4);
      end
      run--;
      if ($urandom_range(0, 3) == 0)
        sw = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 9))
                                         : W'($urandom);
      entry_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 399) == 0);
      tick();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL random i=%0d got=%h want=%h", i, obs, expv);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key_n = 1'b1; sw = '0; entry_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_press();
    test_bounce();
    test_overrun();
    test_release_bounce();
    test_nondigit();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
